// File: rtl/labyrinth_ram_arbiter.sv
// -----------------------------------------------------------------------------
// labyrinth_ram_arbiter
//
// Shares one single-port character RAM between the VGA character fetcher and
// the text writer. The grant for a cycle is decided from that cycle's
// requests and registered onto the RAM port the following cycle; the VGA
// fetcher always wins. Fetched characters come back exactly two cycles after
// the request (one register stage here plus the RAM's one-cycle read). A
// saturating counter flags a writer that has been waiting STARVE_MAX cycles.
//
// Optional feature: define LAB_ARB_WRBUF_EN to put a 2-entry write FIFO
// between the writer and the RAM. The writer is then acked on entry to the
// FIFO and the FIFO head is drained whenever the VGA side is idle.
//
// Ports
//   clk_50MHz_i     system clock, all state on its rising edge
//   rst_async_ha_i  asynchronous active-high reset
//   vga_req_i       VGA fetch request (sampled every cycle)
//   vga_addr_i      VGA fetch address
//   vga_data_o      fetched character (zero when not valid)
//   vga_valid_o     vga_data_o valid this cycle
//   wr_req_i        writer request, held with address/data until acked
//   wr_addr_i       write address
//   wr_data_i       write character
//   wr_ack_o        one-cycle write acceptance pulse
//   ram_we_o        RAM write enable (registered)
//   ram_addr_o      RAM address (registered, holds when idle)
//   ram_din_o       RAM write data (registered)
//   ram_dout_i      RAM read data, one-cycle synchronous latency
//   starved_o       writer has waited STARVE_MAX cycles
// -----------------------------------------------------------------------------
module labyrinth_ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 1023
) (
    input  logic              clk_50MHz_i,
    input  logic              rst_async_ha_i,
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic [DATA_W-1:0] vga_data_o,
    output logic              vga_valid_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              starved_o
);

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_WR   = 2'd2
    } grant_t;

    grant_t             r_grant;
    grant_t             w_grant_next;
    logic               r_rd_pend;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_din;
    logic               r_wr_ack;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [CNT_W-1:0]   w_starve_next;

    // Write source presented to the arbiter, and whether it is waiting.
    logic               w_wr_pending;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [DATA_W-1:0]  w_wr_data;
    logic               w_wr_waiting;
    logic               w_ack_next;

`ifdef LAB_ARB_WRBUF_EN
    logic [ADDR_W-1:0]  r_fifo_addr [2];
    logic [DATA_W-1:0]  r_fifo_data [2];
    logic               r_fifo_wptr;
    logic               r_fifo_rptr;
    logic [1:0]         r_fifo_cnt;
    logic               w_push;
    logic               w_pop;

    // Acceptance looks only at the occupancy at the start of the cycle, so a
    // full FIFO refuses a push even if it drains in the same cycle.
    assign w_push       = wr_req_i & ~r_wr_ack & (r_fifo_cnt != 2'd2);
    assign w_pop        = (w_grant_next == GNT_WR);
    assign w_wr_pending = (r_fifo_cnt != 2'd0);
    assign w_wr_addr    = r_fifo_addr[r_fifo_rptr];
    assign w_wr_data    = r_fifo_data[r_fifo_rptr];
    assign w_wr_waiting = (r_fifo_cnt != 2'd0);
    assign w_ack_next   = w_push;

    always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
        if (rst_async_ha_i) begin
            r_fifo_wptr <= 1'b0;
            r_fifo_rptr <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            if (w_push) r_fifo_wptr <= ~r_fifo_wptr;
            if (w_pop)  r_fifo_rptr <= ~r_fifo_rptr;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_50MHz_i) begin
        if (w_push) begin
            r_fifo_addr[r_fifo_wptr] <= wr_addr_i;
            r_fifo_data[r_fifo_wptr] <= wr_data_i;
        end
    end
`else
    // The ack pulse blocks a re-grant of the same held request.
    assign w_wr_pending = wr_req_i & ~r_wr_ack;
    assign w_wr_addr    = wr_addr_i;
    assign w_wr_data    = wr_data_i;
    assign w_wr_waiting = wr_req_i;
    assign w_ack_next   = (w_grant_next == GNT_WR);
`endif

    // Next-state: VGA has absolute priority, starvation never overrides it.
    always_comb begin
        w_grant_next = GNT_NONE;
        if (vga_req_i) begin
            w_grant_next = GNT_VGA;
        end else if (w_wr_pending) begin
            w_grant_next = GNT_WR;
        end
    end

    always_comb begin
        w_starve_next = '0;
        if (w_wr_waiting && (w_grant_next != GNT_WR)) begin
            w_starve_next = (r_starve_cnt == CNT_MAX) ? r_starve_cnt
                                                       : r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
        if (rst_async_ha_i) begin
            r_grant      <= GNT_NONE;
            r_rd_pend    <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_wr_ack     <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_grant      <= w_grant_next;
            // A read issued on the RAM port this cycle returns data next cycle.
            r_rd_pend    <= (r_grant == GNT_VGA);
            r_ram_we     <= (w_grant_next == GNT_WR);
            r_wr_ack     <= w_ack_next;
            r_starve_cnt <= w_starve_next;
            case (w_grant_next)
                GNT_VGA: r_ram_addr <= vga_addr_i;
                GNT_WR: begin
                    r_ram_addr <= w_wr_addr;
                    r_ram_din  <= w_wr_data;
                end
                default: ;
            endcase
        end
    end

    assign ram_we_o    = r_ram_we;
    assign ram_addr_o  = r_ram_addr;
    assign ram_din_o   = r_ram_din;
    assign wr_ack_o    = r_wr_ack;
    assign vga_valid_o = r_rd_pend;
    assign vga_data_o  = r_rd_pend ? ram_dout_i : '0;
    assign starved_o   = (r_starve_cnt == CNT_MAX);

endmodule

// File: doc/labyrinth_ram_arbiter.md
LABYRINTH_RAM_ARBITER -- requirements
Module: labyrinth_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, RAM address width ({player_pos[7:0], row[1:0], col[5:0]}).
REQ-002 Parameter DATA_W, 8, RAM data width (ASCII character).
REQ-003 Parameter STARVE_MAX, 1023, writer wait-cycle count at which starved_o asserts.
REQ-004 clk_50MHz_i  in  1  system clock; all state on its rising edge.
REQ-005 rst_async_ha_i  in  1  reset, asynchronous, active-high.
REQ-006 vga_req_i  in  1  VGA character-fetch request, sampled every cycle.
REQ-007 vga_addr_i  in  ADDR_W  VGA fetch address.
REQ-008 vga_data_o  out  DATA_W  fetched character.
REQ-009 vga_valid_o  out  1  vga_data_o valid this cycle.
REQ-010 wr_req_i  in  1  text-writer request; held with addr/data until acked.
REQ-011 wr_addr_i  in  ADDR_W  write address.
REQ-012 wr_data_i  in  DATA_W  write character.
REQ-013 wr_ack_o  out  1  one-cycle write acceptance pulse.
REQ-014 ram_we_o  out  1  RAM write enable (registered).
REQ-015 ram_addr_o  out  ADDR_W  RAM address (registered).
REQ-016 ram_din_o  out  DATA_W  RAM write data (registered).
REQ-017 ram_dout_i  in  DATA_W  RAM read data; 1-cycle synchronous read latency.
REQ-018 starved_o  out  1  writer has waited STARVE_MAX cycles.

Function
REQ-019 Grant state SHALL be one of NONE, VGA, WR, decided in cycle N from inputs and driven on ram_* in cycle N+1.
REQ-020 VGA SHALL have absolute priority: vga_req_i=1 in N gives grant VGA, ram_addr_o=vga_addr_i, ram_we_o=0 in N+1.
REQ-021 VGA read latency SHALL be exactly 2 cycles: vga_valid_o=1 and vga_data_o=ram_dout_i in N+2; back-to-back requests yield back-to-back valids.
REQ-022 Writer SHALL be granted in N only if wr_req_i=1, vga_req_i=0 and wr_ack_o=0 in N; then ram_we_o=1, ram_addr_o/ram_din_o = wr_addr_i/wr_data_i and wr_ack_o=1 in N+1.
REQ-023 wr_ack_o=1 in a cycle SHALL block writer grant that cycle (no duplicate write of a held request).
REQ-024 With no request, grant is NONE: ram_we_o=0, ram_addr_o holds last value.
REQ-025 Starve counter SHALL increment each cycle wr_req_i=1 and not granted, saturate at STARVE_MAX, clear to 0 on writer grant or wr_req_i=0.
REQ-026 starved_o SHALL equal (counter==STARVE_MAX); starvation SHALL NOT override VGA priority.
REQ-027 vga_valid_o SHALL never assert in a cycle following a WR or NONE grant.

Reset
REQ-028 Asserting rst_async_ha_i SHALL immediately force grant NONE, ram_we_o=0, ram_addr_o=0, ram_din_o=0, vga_valid_o=0, vga_data_o=0, wr_ack_o=0, counter=0, starved_o=0.
REQ-029 Reads in flight at reset SHALL be discarded; first grant is decided the first clock edge after deassertion.

Configuration
REQ-030 Macro LAB_ARB_WRBUF_EN SHALL include a 2-entry write FIFO between writer and RAM.
REQ-031 With it: wr_ack_o pulses in N+1 whenever wr_req_i=1 in N, FIFO not full and wr_ack_o=0 in N; FIFO head drains to RAM when vga_req_i=0; full FIFO withholds ack; simultaneous push and pop on full FIFO SHALL NOT accept (no ack); counter counts cycles FIFO non-empty and undrained.
REQ-032 Without it: behaviour exactly per REQ-022..REQ-025, no FIFO storage.

Verification
REQ-033 Reset mid-fetch: vga_req_i=1 addr 0x1234, reset asserted cycle N+1 -> vga_valid_o=0 at N+2, all outputs 0.
REQ-034 VGA stream addr 0x0000..0x0003 continuous, ram_dout_i=addr[7:0]+0x41 -> vga_data_o 0x41..0x44 on 4 consecutive cycles, starting 2 cycles after first request.
REQ-035 Collision: vga_req_i=1 and wr_req_i=1 (0x0100, 0x5A) same cycle, vga_req_i drops next cycle -> read issued first, write issued one cycle later, single wr_ack_o pulse.
REQ-036 Held write: wr_req_i=1 for 3 cycles, vga_req_i=0 -> exactly one ram_we_o pulse, one wr_ack_o.
REQ-037 Starvation: vga_req_i=1 continuously, wr_req_i=1 -> starved_o=1 after 1023 cycles; vga_req_i=0 -> write issued, starved_o=0 next cycle.
REQ-038 LAB_ARB_WRBUF_EN, vga_req_i=1: three write requests -> two acks, third withheld until first drain.
